// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, flag layout and control states.
package alu_seq_pkg;

  localparam int unsigned ALU_OP_W    = 4;
  localparam int unsigned ALU_FLAGS_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ROR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_MOV  = 4'd7,
    OP_LD   = 4'd8,
    OP_ST   = 4'd9,
    OP_BLEZ = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // Load operands on start, then accumulate shifted multiplicand per set multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= PW'(a);
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= CNT_W'(WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign done    = r_busy && (r_cnt == '0);
  assign product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes and a persistent flags register.
// Optional iterative multiply enabled by defining ALU_SEQ_MUL_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             jump_flag,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int unsigned WP1  = WIDTH + 1;
  localparam int unsigned SHW1 = SHW + 1;

  alu_state_e r_state, w_state_nxt;
  alu_op_e    w_op;
  logic       w_accept;
  logic       w_is_mul;

  logic [WIDTH-1:0] r_result;
  logic             r_jump;
  logic             r_illegal;
  alu_flags_t       r_flags;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_inv;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_res;
  alu_flags_t       w_fl;
  logic             w_upd;
  logic             w_jump;
  logic             w_ill;

  assign w_op      = alu_op_e'(op);
  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);

`ifdef ALU_SEQ_MUL_EN
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0]   r_result_hi;

  assign w_is_mul = (w_op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_accept && w_is_mul),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  assign result_hi = r_result_hi;
`else
  assign w_is_mul  = 1'b0;
  assign result_hi = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: accepts route to EXEC (multiply) or straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_is_mul ? EXEC : DONE;
      end
      EXEC: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_done) w_state_nxt = DONE;
`else
        w_state_nxt = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_nxt = w_is_mul ? EXEC : DONE;
          else          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} + {1'b0, ~b} + WP1'(1);
  assign w_sh  = b[SHW-1:0];
  assign w_inv = SHW1'(WIDTH) - SHW1'(w_sh);
  assign w_ror = (a >> w_sh) | (a << w_inv);
  assign w_rol = (a << w_sh) | (a >> w_inv);

  // Single-cycle result, flag update and status decode.
  always_comb begin
    w_res  = '0;
    w_fl   = r_flags;
    w_upd  = 1'b0;
    w_jump = 1'b0;
    w_ill  = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res  = w_add[WIDTH-1:0];
        w_upd  = 1'b1;
        w_fl.c = w_add[WIDTH];
        w_fl.v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res  = w_sub[WIDTH-1:0];
        w_upd  = 1'b1;
        w_fl.c = w_sub[WIDTH];
        w_fl.v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  begin w_res = a ^ b; w_upd = 1'b1; w_fl.c = 1'b0; w_fl.v = 1'b0; end
      OP_AND:  begin w_res = a & b; w_upd = 1'b1; w_fl.c = 1'b0; w_fl.v = 1'b0; end
      OP_OR:   begin w_res = a | b; w_upd = 1'b1; w_fl.c = 1'b0; w_fl.v = 1'b0; end
      OP_ROR:  begin w_res = w_ror; w_upd = 1'b1; w_fl.c = 1'b0; w_fl.v = 1'b0; end
      OP_ROL:  begin w_res = w_rol; w_upd = 1'b1; w_fl.c = 1'b0; w_fl.v = 1'b0; end
      OP_MOV:  w_res = b;
      OP_LD:   w_res = b;
      OP_ST:   w_res = a;
      OP_BLEZ: w_jump = a[WIDTH-1] || (a == '0);
      default: w_ill = 1'b1;
    endcase
    if (w_upd) begin
      w_fl.z = (w_res == '0);
      w_fl.n = w_res[WIDTH-1];
    end
  end

  // Output registers: captured on single-cycle accept or multiply completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_flags     <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_result_hi <= '0;
`endif
    end else if (w_accept && !w_is_mul) begin
      r_result    <= w_res;
      r_jump      <= w_jump;
      r_illegal   <= w_ill;
      r_flags     <= w_fl;
`ifdef ALU_SEQ_MUL_EN
      r_result_hi <= '0;
    end else if ((r_state == EXEC) && w_mul_done) begin
      r_result    <= w_mul_product[WIDTH-1:0];
      r_result_hi <= w_mul_product[2*WIDTH-1:WIDTH];
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_flags     <= '{z: (w_mul_product == '0), n: w_mul_product[WIDTH-1], c: 1'b0, v: 1'b0};
`endif
    end
  end

  assign result    = r_result;
  assign jump_flag = r_jump;
  assign illegal   = r_illegal;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model with latency counter, directed and random ops.
module tb_alu_seq;

  localparam int unsigned W = 8;
  localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_ROR = 4'd5, T_ROL = 4'd6;
  localparam logic [3:0] T_BLEZ = 4'd10, T_MUL = 4'd11;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         jump_flag, illegal;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .jump_flag (jump_flag),
    .flags     (flags),
    .illegal   (illegal)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: visible outputs plus cycles left on a pending multiply.
  bit         m_valid = 1'b0;
  int         m_wait = 0;
  logic [7:0] m_res = '0, m_hi = '0;
  logic       m_jump = 1'b0, m_ill = 1'b0;
  logic [3:0] m_flags = '0;
  logic [7:0] p_res, p_hi;
  logic [3:0] p_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs each opcode must produce, from plain integer arithmetic.
  task automatic model_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] res, output logic [7:0] hi, output logic jmp,
                          output logic ill, output logic upd, output logic [3:0] fl,
                          output bit mul);
    int unsigned ua, ub, k, p;
    int          sa, sb, ss;
    bit          c, v;
    ua = x; ub = y; k = ub % W;
    sa = (ua >= 128) ? int'(ua) - 256 : int'(ua);
    sb = (ub >= 128) ? int'(ub) - 256 : int'(ub);
    res = '0; hi = '0; jmp = 0; ill = 0; upd = 0; fl = m_flags; mul = 0; c = 0; v = 0;
    case (o)
      4'd0: begin res = 8'(ua + ub); upd = 1; c = (ua + ub) > 255;
                  ss = sa + sb; v = (ss > 127) || (ss < -128); end
      4'd1: begin res = 8'(ua - ub); upd = 1; c = (ua >= ub);
                  ss = sa - sb; v = (ss > 127) || (ss < -128); end
      4'd2: begin res = x ^ y; upd = 1; end
      4'd3: begin res = x & y; upd = 1; end
      4'd4: begin res = x | y; upd = 1; end
      4'd5: begin res = 8'(((ua >> k) | (ua << (W - k))) & 32'hFF); upd = 1; end
      4'd6: begin res = 8'(((ua << k) | (ua >> (W - k))) & 32'hFF); upd = 1; end
      4'd7, 4'd8: res = y;
      4'd9: res = x;
      4'd10: jmp = (sa <= 0);
      4'd11: begin
        if (MUL_EN) begin
          p = ua * ub; res = 8'(p & 32'hFF); hi = 8'(p >> 8); mul = 1;
          fl = {p == 0, res[7], 1'b0, 1'b0};
        end else begin
          ill = 1;
        end
      end
      default: ill = 1;
    endcase
    if (upd) fl = {res == 8'h00, res[7], c, v};
  endtask

  // One clock: drive inputs, check in_ready, advance the model, compare after the edge.
  task automatic step(input logic iv, input logic [3:0] iop, input logic [7:0] ia,
                      input logic [7:0] ib, input logic ordy);
    bit         rdy, acc, mul;
    logic [7:0] r, h;
    logic       j, il, up;
    logic [3:0] f;
    in_valid = iv; op = iop; a = ia; b = ib; out_ready = ordy;
    rdy = (m_wait == 0) && (!m_valid || ordy);
    #1;
    check("in_ready", in_ready, rdy);
    acc = iv && rdy;
    if (m_wait != 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1; m_res = p_res; m_hi = p_hi; m_jump = 0; m_ill = 0; m_flags = p_flags;
      end
    end else if (m_valid && ordy && !acc) begin
      m_valid = 0;
    end
    if (acc) begin
      model_op(iop, ia, ib, r, h, j, il, up, f, mul);
      if (mul) begin
        m_valid = 0; m_wait = W + 1; p_res = r; p_hi = h; p_flags = f;
      end else begin
        m_valid = 1; m_res = r; m_hi = h; m_jump = j; m_ill = il;
        if (up) m_flags = f;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, m_valid);
    check("flags", flags, m_flags);
    if (m_valid) begin
      check("result", result, m_res);
      check("result_hi", result_hi, m_hi);
      check("jump_flag", jump_flag, m_jump);
      check("illegal", illegal, m_ill);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    in_valid = 0; op = '0; a = '0; b = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_flags", flags, 0);
    check("rst_jump", jump_flag, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1;

    step(1, T_ADD, 8'h7F, 8'h01, 1);
    check("add_result", result, 8'h80);
    check("add_flags", flags, 4'h5);
    step(1, T_ROR, 8'h81, 8'h09, 1);
    check("ror_result", result, 8'hC0);
    step(1, T_ROL, 8'h81, 8'h08, 1);
    check("rol_result", result, 8'h81);
    check("rol_flags", flags, 4'h4);
    step(0, T_ADD, 8'h00, 8'h00, 1);

`ifdef ALU_SEQ_MUL_EN
    step(1, T_MUL, 8'hFF, 8'hFF, 1);
    for (int i = 1; i <= 8; i++) begin
      check("mul_exec_in_ready", in_ready, 0);
      step(1, T_ADD, 8'($urandom), 8'($urandom), 1);
      check("mul_exec_out_valid", out_valid, 0);
    end
    check("mul_exec_in_ready", in_ready, 0);
    step(0, T_ADD, 8'($urandom), 8'($urandom), 0);
    check("mul_latency_valid", out_valid, 1);
    check("mul_lo", result, 8'h01);
    check("mul_hi", result_hi, 8'hFE);
    check("mul_flags", flags, 4'h0);
    step(0, T_ADD, 8'h00, 8'h00, 1);
`else
    step(1, T_MUL, 8'hFF, 8'hFF, 1);
    check("mul_off_illegal", illegal, 1);
    check("mul_off_result", result, 0);
    check("mul_off_hi", result_hi, 0);
    check("mul_off_flags", flags, 4'h4);
    step(0, T_ADD, 8'h00, 8'h00, 1);
`endif

    step(1, T_ADD, 8'h03, 8'h04, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, T_SUB, 8'h05, 8'h05, 0);
      check("bp_result_hold", result, 8'h07);
      check("bp_in_ready", in_ready, 0);
    end
    step(1, T_SUB, 8'h05, 8'h05, 1);
    check("bp_sub_result", result, 8'h00);
    check("bp_sub_flags", flags, 4'hA);

    step(1, T_BLEZ, 8'h80, 8'h00, 1);
    check("blez_neg", jump_flag, 1);
    check("blez_neg_flags", flags, 4'hA);
    step(1, T_BLEZ, 8'h01, 8'h00, 1);
    check("blez_pos", jump_flag, 0);
    check("blez_pos_flags", flags, 4'hA);
    step(1, T_BLEZ, 8'h00, 8'h00, 1);
    check("blez_zero", jump_flag, 1);
    check("blez_zero_result", result, 0);
    step(1, 4'd14, 8'h12, 8'h34, 1);
    check("undef_illegal", illegal, 1);
    check("undef_flags", flags, 4'hA);
    step(0, T_ADD, 8'h00, 8'h00, 1);

    repeat (3000)
      step($urandom_range(0, 9) < 7, 4'($urandom), 8'($urandom), 8'($urandom),
           $urandom_range(0, 9) < 7);

`ifdef ALU_SEQ_MUL_EN
    step(1, T_MUL, 8'h12, 8'h34, 1);
    repeat (3) step(0, T_ADD, 8'h00, 8'h00, 1);
`else
    step(1, T_ADD, 8'h09, 8'h09, 0);
    step(0, T_ADD, 8'h00, 8'h00, 0);
`endif
    #2;
    rst_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_result_hi", result_hi, 0);
    check("arst_flags", flags, 0);
    check("arst_jump", jump_flag, 0);
    check("arst_illegal", illegal, 0);
    check("arst_in_ready", in_ready, 1);
    m_valid = 0; m_wait = 0; m_flags = '0; m_res = '0; m_hi = '0; m_jump = 0; m_ill = 0;
    @(negedge clk);
    rst_n = 1;
    step(1, T_ADD, 8'h01, 8'h01, 1);
    check("post_rst_add", result, 8'h02);
    check("post_rst_flags", flags, 4'h0);
    step(0, T_ADD, 8'h00, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
